bcd_sum_display: RTL

//  Downstream consumer of the single-digit BCD adder. Collects digit-serial sums,

---
 rtl/bcd_sum_display.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bcd_sum_display.sv
// Collects digit-serial BCD sums (LSD first) into a 4-digit register and drives a
// multiplexed active-low 4-digit 7-segment display, with a sticky non-BCD flag.
module bcd_sum_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] sum_in,
    input  logic       cout_in,
    input  logic       clear,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done,
    output logic       bcd_err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [3:0][3:0]   r_digits;      // [3] = d3 (MSD), [0] = d0 (LSD)
    logic              r_carry;
    logic [1:0]        r_dig_cnt;
    logic [CNT_W-1:0]  r_refresh_cnt;
    logic [1:0]        r_scan_idx;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [3:0]        r_an;
    logic              r_frame_done;
    logic              r_bcd_err;

    logic              w_load;
    logic              w_refresh_wrap;
    logic [3:0]        w_zero;
    logic [3:0]        w_blank;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    assign w_load         = load && !clear;
    assign w_refresh_wrap = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));

    // A digit is a leading zero only if it and every digit above it are zero.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_zero[k] = (r_digits[k] == 4'd0);
        end
        w_blank    = 4'b0000;
        if (BLANK_LZ) begin
            w_blank[3] = w_zero[3];
            w_blank[2] = w_zero[3] && w_zero[2];
            w_blank[1] = w_zero[3] && w_zero[2] && w_zero[1];
        end
        w_digit    = r_digits[r_scan_idx];
        w_seg_next = w_blank[r_scan_idx] ? SEG_BLANK : seg_decode(w_digit);
    end

    // NOTE: the digit store is a handful of flops that must read 0 after reset,
    // so it is reset like any other register rather than left as uninitialised RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits     <= '0;
            r_carry      <= 1'b0;
            r_dig_cnt    <= 2'd0;
            r_frame_done <= 1'b0;
            r_bcd_err    <= 1'b0;
        end else begin
            r_frame_done <= w_load && (r_dig_cnt == 2'd3);
            if (clear) begin
                r_digits  <= '0;
                r_carry   <= 1'b0;
                r_dig_cnt <= 2'd0;
                r_bcd_err <= 1'b0;
            end else if (load) begin
                r_digits  <= {sum_in, r_digits[3:1]};
                r_carry   <= cout_in;
                r_dig_cnt <= r_dig_cnt + 2'd1;
                if (sum_in > 4'd9) begin
                    r_bcd_err <= 1'b1;
                end
            end
        end
    end

    // Scan logic is independent of clear so the display never glitches on a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= 2'd0;
            r_an          <= 4'b1110;
            r_seg         <= 7'b1000000;
            r_dp          <= 1'b1;
        end else begin
            if (w_refresh_wrap) begin
                r_refresh_cnt <= '0;
                r_scan_idx    <= r_scan_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_scan_idx);
            r_seg <= w_seg_next;
            r_dp  <= !((r_scan_idx == 2'd3) && r_carry);
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign bcd_err    = r_bcd_err;

endmodule
